// File: rtl/batch_issue_sequencer_pkg.sv
// Shared encodings and table widths for the batch issue sequencer and its output register.
package batch_issue_sequencer_pkg;

  localparam int TBL_REQ_W  = 6;
  localparam int TBL_SRR_W  = 5;
  localparam int TBL_SBR_W  = 4;
  localparam int TBL_ROW_W  = 16;
  localparam int TBL_BG_W   = 2;
  localparam int TBL_BANK_W = 2;
  localparam int TBL_RD_LAT = 2;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_ACT  = 2'b01,
    CMD_RD   = 2'b10,
    CMD_PRE  = 2'b11
  } cmd_type_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_SBR,
    ST_RD_SRR,
    ST_RD_ROW,
    ST_ISSUE_ACT,
    ST_ISSUE_RD,
    ST_RD_REQ,
    ST_ISSUE_PRE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/batch_issue_sequencer_issue_cmd_reg.sv
// Single-entry valid/ready command register; fields only change when the slot is free or draining.
module issue_cmd_reg
  import batch_issue_sequencer_pkg::*;
#(
  parameter int REQ_W  = TBL_REQ_W,
  parameter int ROW_W  = TBL_ROW_W,
  parameter int BG_W   = TBL_BG_W,
  parameter int BANK_W = TBL_BANK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [1:0]        push_type,
  input  logic [BG_W-1:0]   push_bg,
  input  logic [BANK_W-1:0] push_bank,
  input  logic [ROW_W-1:0]  push_row,
  input  logic [REQ_W-1:0]  push_req_id,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [1:0]        cmd_type,
  output logic [BG_W-1:0]   cmd_bg,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [REQ_W-1:0]  cmd_req_id
);

  logic can_load;

  // A pending command is never overwritten until it has been accepted.
  assign can_load = !cmd_valid || cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_valid  <= 1'b0;
      cmd_type   <= CMD_NONE;
      cmd_bg     <= '0;
      cmd_bank   <= '0;
      cmd_row    <= '0;
      cmd_req_id <= '0;
    end else if (push && can_load) begin
      cmd_valid  <= 1'b1;
      cmd_type   <= push_type;
      cmd_bg     <= push_bg;
      cmd_bank   <= push_bank;
      cmd_row    <= push_row;
      cmd_req_id <= push_req_id;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/batch_issue_sequencer.sv
// Walks one SBR's SRR chain from the scheduler tables and emits ACT / RD... / PRE per SRR.
module batch_issue_sequencer
  import batch_issue_sequencer_pkg::*;
#(
  parameter int REQ_W  = TBL_REQ_W,
  parameter int SRR_W  = TBL_SRR_W,
  parameter int SBR_W  = TBL_SBR_W,
  parameter int ROW_W  = TBL_ROW_W,
  parameter int BG_W   = TBL_BG_W,
  parameter int BANK_W = TBL_BANK_W,
  parameter int RD_LAT = TBL_RD_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SBR_W-1:0]  sbr_id,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [SBR_W-1:0]  sbr_rd_addr,
  input  logic [SRR_W-1:0]  sbr_rd_head_srr,
  input  logic [SRR_W-1:0]  sbr_rd_row_count,
  input  logic [BG_W-1:0]   sbr_rd_bank_group,
  input  logic [BANK_W-1:0] sbr_rd_bank,
  output logic [SRR_W-1:0]  srr_rd_addr,
  input  logic [REQ_W-1:0]  srr_rd_head_req,
  input  logic [REQ_W-1:0]  srr_rd_count,
  input  logic [SRR_W-1:0]  srr_rd_next,
  output logic [REQ_W-1:0]  req_rd_addr,
  input  logic [ROW_W-1:0]  req_rd_row,
  input  logic [REQ_W-1:0]  req_rd_next,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [BG_W-1:0]   cmd_bg,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [ROW_W-1:0]  cmd_row,
  output logic [REQ_W-1:0]  cmd_req_id,
  output logic [SRR_W-1:0]  rows_issued,
  output logic [REQ_W-1:0]  reqs_issued
);

  localparam int WAIT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_e              state, state_nxt;
  logic                abort_q;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rd_state, rd_sample, hs;
  logic [SBR_W-1:0]    sbr_q;
  logic [SRR_W-1:0]    srr_ptr, rows_left, next_srr_q;
  logic [REQ_W-1:0]    req_ptr, reqs_left;
  logic [ROW_W-1:0]    row_q;
  logic [BG_W-1:0]     bg_q;
  logic [BANK_W-1:0]   bank_q;
  logic                push;
  cmd_type_e           push_type;
  logic [ROW_W-1:0]    push_row;
  logic [REQ_W-1:0]    push_req_id;

  // Table addresses come straight from the walk pointers, so they are registered.
  assign sbr_rd_addr = sbr_q;
  assign srr_rd_addr = srr_ptr;
  assign req_rd_addr = req_ptr;
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign hs          = cmd_valid && cmd_ready;
  assign rd_state    = (state == ST_RD_SBR) || (state == ST_RD_SRR) ||
                       (state == ST_RD_ROW) || (state == ST_RD_REQ);
  assign rd_sample   = rd_state && (wait_cnt == WAIT_W'(RD_LAT));

  always_comb begin
    state_nxt   = state;
    push        = 1'b0;
    push_type   = CMD_PRE;
    push_row    = row_q;
    push_req_id = '0;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_RD_SBR;
      ST_RD_SBR:    if (rd_sample)
                      state_nxt = (sbr_rd_row_count == '0 || abort_q) ? ST_DONE : ST_RD_SRR;
      ST_RD_SRR:    if (rd_sample) state_nxt = abort_q ? ST_DONE : ST_RD_ROW;
      ST_RD_ROW:    if (rd_sample) begin
                      if (abort_q) begin
                        state_nxt = ST_DONE;
                      end else begin
                        push      = 1'b1;
                        push_type = CMD_ACT;
                        push_row  = req_rd_row;
                        state_nxt = ST_ISSUE_ACT;
                      end
                    end
      ST_ISSUE_ACT: if (hs) begin
                      push = 1'b1;
                      if (abort_q || reqs_left == '0) begin
                        state_nxt = ST_ISSUE_PRE;
                      end else begin
                        push_type   = CMD_RD;
                        push_req_id = req_ptr;
                        state_nxt   = ST_ISSUE_RD;
                      end
                    end
      ST_ISSUE_RD:  if (hs) begin
                      if (abort_q || reqs_left == REQ_W'(1)) begin
                        push      = 1'b1;
                        state_nxt = ST_ISSUE_PRE;
                      end else begin
                        state_nxt = ST_RD_REQ;
                      end
                    end
      // The row is open here, so an abort still has to close it with PRE.
      ST_RD_REQ:    if (rd_sample) begin
                      push = 1'b1;
                      if (abort_q) begin
                        state_nxt = ST_ISSUE_PRE;
                      end else begin
                        push_type   = CMD_RD;
                        push_req_id = req_rd_next;
                        state_nxt   = ST_ISSUE_RD;
                      end
                    end
      ST_ISSUE_PRE: if (hs)
                      state_nxt = (abort_q || rows_left == SRR_W'(1)) ? ST_DONE : ST_RD_SRR;
      ST_DONE:      state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      abort_q     <= 1'b0;
      wait_cnt    <= '0;
      sbr_q       <= '0;
      srr_ptr     <= '0;
      req_ptr     <= '0;
      rows_left   <= '0;
      reqs_left   <= '0;
      rows_issued <= '0;
      reqs_issued <= '0;
    end else begin
      state    <= state_nxt;
      abort_q  <= (state == ST_IDLE) ? 1'b0 : (abort_q | abort);
      wait_cnt <= (rd_state && !rd_sample) ? wait_cnt + 1'b1 : '0;
      case (state)
        ST_IDLE:      if (start) begin
                        sbr_q       <= sbr_id;
                        rows_issued <= '0;
                        reqs_issued <= '0;
                      end
        ST_RD_SBR:    if (rd_sample) begin
                        srr_ptr   <= sbr_rd_head_srr;
                        rows_left <= sbr_rd_row_count;
                      end
        ST_RD_SRR:    if (rd_sample) begin
                        req_ptr   <= srr_rd_head_req;
                        reqs_left <= srr_rd_count;
                      end
        ST_ISSUE_ACT: if (hs) rows_issued <= rows_issued + 1'b1;
        ST_ISSUE_RD:  if (hs) begin
                        reqs_issued <= reqs_issued + 1'b1;
                        reqs_left   <= reqs_left - 1'b1;
                      end
        ST_RD_REQ:    if (rd_sample) req_ptr <= req_rd_next;
        ST_ISSUE_PRE: if (hs) begin
                        rows_left <= rows_left - 1'b1;
                        if (state_nxt == ST_RD_SRR) srr_ptr <= next_srr_q;
                      end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_RD_SBR && rd_sample) begin
      bg_q   <= sbr_rd_bank_group;
      bank_q <= sbr_rd_bank;
    end
    if (state == ST_RD_SRR && rd_sample) next_srr_q <= srr_rd_next;
    if (state == ST_RD_ROW && rd_sample) row_q <= req_rd_row;
  end

  issue_cmd_reg #(
    .REQ_W  (REQ_W),
    .ROW_W  (ROW_W),
    .BG_W   (BG_W),
    .BANK_W (BANK_W)
  ) u_cmd_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_type   (push_type),
    .push_bg     (bg_q),
    .push_bank   (bank_q),
    .push_row    (push_row),
    .push_req_id (push_req_id),
    .cmd_ready   (cmd_ready),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_bg      (cmd_bg),
    .cmd_bank    (cmd_bank),
    .cmd_row     (cmd_row),
    .cmd_req_id  (cmd_req_id)
  );

endmodule

// File: tb/tb_batch_issue_sequencer.sv
// Directed bench: models the three scheduler tables with a 2-cycle read pipeline and logs accepted commands.
module tb_batch_issue_sequencer;

  localparam logic [1:0] T_ACT = 2'b01;
  localparam logic [1:0] T_RD  = 2'b10;
  localparam logic [1:0] T_PRE = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, cmd_ready;
  logic [3:0]  sbr_id;
  logic        busy, done, cmd_valid;
  logic [3:0]  sbr_rd_addr;
  logic [4:0]  sbr_rd_head_srr, sbr_rd_row_count, srr_rd_addr, srr_rd_next, rows_issued;
  logic [1:0]  sbr_rd_bank_group, sbr_rd_bank, cmd_type, cmd_bg, cmd_bank;
  logic [5:0]  srr_rd_head_req, srr_rd_count, req_rd_addr, req_rd_next, cmd_req_id, reqs_issued;
  logic [15:0] req_rd_row, cmd_row;

  logic [4:0]  sbr_head [16];
  logic [4:0]  sbr_cnt  [16];
  logic [1:0]  sbr_bg   [16];
  logic [1:0]  sbr_bank [16];
  logic [5:0]  srr_head [32];
  logic [5:0]  srr_cnt  [32];
  logic [4:0]  srr_next [32];
  logic [15:0] req_row  [64];
  logic [5:0]  req_next [64];

  logic [3:0]  sbr_a1 = '0, sbr_a2 = '0;
  logic [4:0]  srr_a1 = '0, srr_a2 = '0;
  logic [5:0]  req_a1 = '0, req_a2 = '0;

  logic [1:0]  log_type [64];
  logic [15:0] log_row  [64];
  logic [5:0]  log_id   [64];
  logic [3:0]  log_bgbk [64];
  int          log_n = 0, stab_err = 0, valid_seen = 0;
  logic        prev_stall = 1'b0;
  logic [1:0]  p_type, p_bg, p_bank;
  logic [15:0] p_row;
  logic [5:0]  p_id;

  int          tests = 0, failed = 0;
  int          ready_mode = 0;

  always #5 clk = ~clk;

  batch_issue_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sbr_id(sbr_id), .abort(abort),
    .busy(busy), .done(done),
    .sbr_rd_addr(sbr_rd_addr), .sbr_rd_head_srr(sbr_rd_head_srr),
    .sbr_rd_row_count(sbr_rd_row_count), .sbr_rd_bank_group(sbr_rd_bank_group),
    .sbr_rd_bank(sbr_rd_bank),
    .srr_rd_addr(srr_rd_addr), .srr_rd_head_req(srr_rd_head_req),
    .srr_rd_count(srr_rd_count), .srr_rd_next(srr_rd_next),
    .req_rd_addr(req_rd_addr), .req_rd_row(req_rd_row), .req_rd_next(req_rd_next),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_req_id(cmd_req_id),
    .rows_issued(rows_issued), .reqs_issued(reqs_issued)
  );

  // Two register stages between address and data.
  always @(posedge clk) begin
    sbr_a1 <= sbr_rd_addr; sbr_a2 <= sbr_a1;
    srr_a1 <= srr_rd_addr; srr_a2 <= srr_a1;
    req_a1 <= req_rd_addr; req_a2 <= req_a1;
  end

  assign sbr_rd_head_srr   = sbr_head[sbr_a2];
  assign sbr_rd_row_count  = sbr_cnt[sbr_a2];
  assign sbr_rd_bank_group = sbr_bg[sbr_a2];
  assign sbr_rd_bank       = sbr_bank[sbr_a2];
  assign srr_rd_head_req   = srr_head[srr_a2];
  assign srr_rd_count      = srr_cnt[srr_a2];
  assign srr_rd_next       = srr_next[srr_a2];
  assign req_rd_row        = req_row[req_a2];
  assign req_rd_next       = req_next[req_a2];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!cmd_valid || cmd_type !== p_type || cmd_row !== p_row ||
                         cmd_req_id !== p_id || cmd_bg !== p_bg || cmd_bank !== p_bank))
        stab_err <= stab_err + 1;
      if (cmd_valid) valid_seen <= valid_seen + 1;
      if (cmd_valid && cmd_ready) begin
        if (log_n < 64) begin
          log_type[log_n] <= cmd_type;
          log_row[log_n]  <= cmd_row;
          log_id[log_n]   <= cmd_req_id;
          log_bgbk[log_n] <= {cmd_bg, cmd_bank};
        end
        log_n <= log_n + 1;
      end
      prev_stall <= cmd_valid && !cmd_ready;
      p_type <= cmd_type; p_row <= cmd_row; p_id <= cmd_req_id;
      p_bg   <= cmd_bg;   p_bank <= cmd_bank;
    end
  end

  // Ready driver: mode 0 always ready, mode 1 holds each command off for 5 cycles.
  initial begin
    int stall_cnt;
    stall_cnt = 0;
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) begin
        cmd_ready = 1'b1;
      end else begin
        if (cmd_ready) stall_cnt = 0;
        if (cmd_valid && stall_cnt < 5) begin
          cmd_ready = 1'b0;
          stall_cnt = stall_cnt + 1;
        end else begin
          cmd_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cmd(input string tag, input int idx, input logic [1:0] t,
                         input logic [15:0] row, input logic [5:0] id, input logic [3:0] bgbk);
    chk($sformatf("%s[%0d].type", tag, idx), {30'd0, log_type[idx]}, {30'd0, t});
    chk($sformatf("%s[%0d].row", tag, idx), {16'd0, log_row[idx]}, {16'd0, row});
    chk($sformatf("%s[%0d].id", tag, idx), {26'd0, log_id[idx]}, {26'd0, id});
    chk($sformatf("%s[%0d].bgbank", tag, idx), {28'd0, log_bgbk[idx]}, {28'd0, bgbk});
  endtask

  task automatic start_batch(input logic [3:0] id);
    @(posedge clk); #1;
    sbr_id = id;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < max_cycles);
  endtask

  initial begin
    int n, base, vbase, sbase;
    for (int i = 0; i < 16; i++) begin
      sbr_head[i] = '0; sbr_cnt[i] = '0; sbr_bg[i] = '0; sbr_bank[i] = '0;
    end
    for (int i = 0; i < 32; i++) begin
      srr_head[i] = '0; srr_cnt[i] = '0; srr_next[i] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      req_row[i] = '0; req_next[i] = '0;
      log_type[i] = '0; log_row[i] = '0; log_id[i] = '0; log_bgbk[i] = '0;
    end
    sbr_head[3]  = 5'd0; sbr_cnt[3]  = 5'd1; sbr_bg[3]  = 2'd2; sbr_bank[3]  = 2'd1;
    sbr_head[7]  = 5'd1; sbr_cnt[7]  = 5'd2; sbr_bg[7]  = 2'd1; sbr_bank[7]  = 2'd3;
    sbr_head[9]  = 5'd2; sbr_cnt[9]  = 5'd0; sbr_bg[9]  = 2'd0; sbr_bank[9]  = 2'd2;
    sbr_head[12] = 5'd4; sbr_cnt[12] = 5'd1; sbr_bg[12] = 2'd3; sbr_bank[12] = 2'd0;
    srr_head[0] = 6'd2;  srr_cnt[0] = 6'd2; srr_next[0] = 5'd0;
    srr_head[1] = 6'd10; srr_cnt[1] = 6'd1; srr_next[1] = 5'd4;
    srr_head[4] = 6'd20; srr_cnt[4] = 6'd3; srr_next[4] = 5'd0;
    req_row[2]  = 16'h0040; req_next[2]  = 6'd5;
    req_row[5]  = 16'h0077; req_next[5]  = 6'd0;
    req_row[10] = 16'h1234; req_next[10] = 6'd11;
    req_row[20] = 16'hBEEF; req_next[20] = 6'd33;
    req_row[33] = 16'h1111; req_next[33] = 6'd40;
    req_row[40] = 16'h2222; req_next[40] = 6'd0;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sbr_id = '0; ready_mode = 0;
    repeat (2) @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("rst.cmd_fields", {8'd0, cmd_type, cmd_bg, cmd_bank, cmd_row, cmd_req_id}, 32'd0);
    chk("rst.counters", {21'd0, rows_issued, reqs_issued}, 32'd0);
    chk("rst.addrs", {17'd0, sbr_rd_addr, srr_rd_addr, req_rd_addr}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // SBR 3: one SRR, requests 2 -> 5, always ready.
    base = log_n;
    start_batch(4'd3);
    chk("s1.busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(300, n);
    #1;
    chk("s1.done", {31'd0, done}, 32'd1);
    chk("s1.ncmd", log_n - base, 32'd4);
    exp_cmd("s1", base + 0, T_ACT, 16'h0040, 6'd0, 4'b1001);
    exp_cmd("s1", base + 1, T_RD,  16'h0040, 6'd2, 4'b1001);
    exp_cmd("s1", base + 2, T_RD,  16'h0040, 6'd5, 4'b1001);
    exp_cmd("s1", base + 3, T_PRE, 16'h0040, 6'd0, 4'b1001);
    chk("s1.rows_issued", {27'd0, rows_issued}, 32'd1);
    chk("s1.reqs_issued", {26'd0, reqs_issued}, 32'd2);
    @(negedge clk);
    chk("s1.done_one_cycle", {31'd0, done}, 32'd0);
    chk("s1.busy_clear", {31'd0, busy}, 32'd0);

    // SBR 7: SRR 1 (one request) then SRR 4 (three requests).
    base = log_n;
    start_batch(4'd7);
    wait_done(500, n);
    #1;
    chk("s2.done", {31'd0, done}, 32'd1);
    chk("s2.ncmd", log_n - base, 32'd8);
    exp_cmd("s2", base + 0, T_ACT, 16'h1234, 6'd0,  4'b0111);
    exp_cmd("s2", base + 1, T_RD,  16'h1234, 6'd10, 4'b0111);
    exp_cmd("s2", base + 2, T_PRE, 16'h1234, 6'd0,  4'b0111);
    exp_cmd("s2", base + 3, T_ACT, 16'hBEEF, 6'd0,  4'b0111);
    exp_cmd("s2", base + 4, T_RD,  16'hBEEF, 6'd20, 4'b0111);
    exp_cmd("s2", base + 5, T_RD,  16'hBEEF, 6'd33, 4'b0111);
    exp_cmd("s2", base + 6, T_RD,  16'hBEEF, 6'd40, 4'b0111);
    exp_cmd("s2", base + 7, T_PRE, 16'hBEEF, 6'd0,  4'b0111);
    chk("s2.rows_issued", {27'd0, rows_issued}, 32'd2);
    chk("s2.reqs_issued", {26'd0, reqs_issued}, 32'd4);

    // SBR 3 again with every command held off for 5 cycles.
    ready_mode = 1;
    base  = log_n;
    vbase = valid_seen;
    sbase = stab_err;
    start_batch(4'd3);
    wait_done(500, n);
    #1;
    chk("s3.done", {31'd0, done}, 32'd1);
    chk("s3.ncmd", log_n - base, 32'd4);
    chk("s3.valid_cycles", valid_seen - vbase, 32'd24);
    chk("s3.stable", stab_err - sbase, 32'd0);
    exp_cmd("s3", base + 0, T_ACT, 16'h0040, 6'd0, 4'b1001);
    exp_cmd("s3", base + 1, T_RD,  16'h0040, 6'd2, 4'b1001);
    exp_cmd("s3", base + 2, T_RD,  16'h0040, 6'd5, 4'b1001);
    exp_cmd("s3", base + 3, T_PRE, 16'h0040, 6'd0, 4'b1001);
    chk("s3.reqs_issued", {26'd0, reqs_issued}, 32'd2);

    // SBR 9: empty SBR, done right after the table read completes.
    ready_mode = 0;
    base  = log_n;
    vbase = valid_seen;
    start_batch(4'd9);
    wait_done(50, n);
    #1;
    chk("s4.done", {31'd0, done}, 32'd1);
    chk("s4.latency", n, 32'd4);
    chk("s4.no_valid", valid_seen - vbase, 32'd0);
    chk("s4.counters", {21'd0, rows_issued, reqs_issued}, 32'd0);
    @(negedge clk);
    chk("s4.busy_clear", {31'd0, busy}, 32'd0);

    // SBR 12: abort while RD 33 is stalled.
    ready_mode = 1;
    base  = log_n;
    sbase = stab_err;
    start_batch(4'd12);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_valid && cmd_type == T_RD && cmd_req_id == 6'd33 && !cmd_ready) && n < 300);
    chk("s5.rd33_stalled", {31'd0, (n < 300)}, 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(300, n);
    #1;
    chk("s5.done", {31'd0, done}, 32'd1);
    chk("s5.ncmd", log_n - base, 32'd4);
    chk("s5.stable", stab_err - sbase, 32'd0);
    exp_cmd("s5", base + 0, T_ACT, 16'hBEEF, 6'd0,  4'b1100);
    exp_cmd("s5", base + 1, T_RD,  16'hBEEF, 6'd20, 4'b1100);
    exp_cmd("s5", base + 2, T_RD,  16'hBEEF, 6'd33, 4'b1100);
    exp_cmd("s5", base + 3, T_PRE, 16'hBEEF, 6'd0,  4'b1100);
    chk("s5.rows_issued", {27'd0, rows_issued}, 32'd1);
    chk("s5.reqs_issued", {26'd0, reqs_issued}, 32'd2);

    // Reset while a RD is pending, then a clean run.
    start_batch(4'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cmd_valid && cmd_type == T_RD) && n < 300);
    chk("s6.in_issue_rd", {31'd0, (n < 300)}, 32'd1);
    chk("s6.rows_before_rst", {27'd0, rows_issued}, 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("s6.rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("s6.rst_counters", {21'd0, rows_issued, reqs_issued}, 32'd0);
    chk("s6.rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    chk("s6.no_done", {31'd0, done}, 32'd0);
    ready_mode = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    base = log_n;
    start_batch(4'd3);
    wait_done(300, n);
    #1;
    chk("s6.done", {31'd0, done}, 32'd1);
    chk("s6.ncmd", log_n - base, 32'd4);
    exp_cmd("s6", base + 0, T_ACT, 16'h0040, 6'd0, 4'b1001);
    exp_cmd("s6", base + 1, T_RD,  16'h0040, 6'd2, 4'b1001);
    exp_cmd("s6", base + 2, T_RD,  16'h0040, 6'd5, 4'b1001);
    exp_cmd("s6", base + 3, T_PRE, 16'h0040, 6'd0, 4'b1001);
    chk("s6.counters", {21'd0, rows_issued, reqs_issued}, {21'd0, 5'd1, 6'd2});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
